// File: rtl/snn_current_scheduler_if.sv
// snn_current_scheduler_if: start/spike input, weight memory, shared calculator and current store signals.
// master = scheduler side, slave = surrounding layer (source, memory, calculator, store).
interface snn_current_scheduler_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic [7:0]       input_spikes;
    logic             w_re;
    logic [IDX_W-1:0] w_addr;
    logic [15:0]      w_data;
    logic [7:0]       calc_spikes;
    logic [15:0]      calc_weights;
    logic [4:0]       calc_current;
    logic             cur_we;
    logic [IDX_W-1:0] cur_addr;
    logic [4:0]       cur_data;
    logic             busy;
    logic             done;

    modport master (
        input  start, input_spikes, w_data, calc_current,
        output w_re, w_addr, calc_spikes, calc_weights, cur_we, cur_addr, cur_data, busy, done
    );

    modport slave (
        output start, input_spikes, w_data, calc_current,
        input  w_re, w_addr, calc_spikes, calc_weights, cur_we, cur_addr, cur_data, busy, done
    );
endinterface

// File: rtl/snn_current_scheduler.sv
// snn_current_scheduler: sequences one shared weighted-sum calculator over N_NEURONS neurons.
// Optional SKIP_SILENT_EN: an all-zero spike vector writes zero currents at one neuron per cycle.
module snn_current_scheduler #(
    parameter int N_NEURONS = 8,
    parameter int IDX_W     = 4
) (
    input logic clk,
    input logic rst_n,
    snn_current_scheduler_if.master bus
);
`ifdef SKIP_SILENT_EN
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, CALC, ZERO} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, CALC} state_t;
`endif

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       spike_reg;
    logic             last;

    assign last            = idx == LAST;
    assign bus.w_re        = state == FETCH;
    assign bus.w_addr      = idx;
    assign bus.calc_spikes = spike_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            idx              <= '0;
            spike_reg        <= '0;
            bus.calc_weights <= '0;
            bus.cur_we       <= 1'b0;
            bus.cur_addr     <= '0;
            bus.cur_data     <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.cur_we <= 1'b0;
            bus.done   <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    spike_reg <= bus.input_spikes;
                    idx       <= '0;
                    bus.busy  <= 1'b1;
`ifdef SKIP_SILENT_EN
                    state     <= (bus.input_spikes == 8'h00) ? ZERO : FETCH;
`else
                    state     <= FETCH;
`endif
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    bus.calc_weights <= bus.w_data;
                    state            <= CALC;
                end
                CALC: begin
                    bus.cur_we   <= 1'b1;
                    bus.cur_addr <= idx;
                    bus.cur_data <= bus.calc_current;
                    if (last) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= FETCH;
                    end
                end
`ifdef SKIP_SILENT_EN
                // Silent input: every neuron's current is zero, no weight fetch needed.
                ZERO: begin
                    bus.cur_we   <= 1'b1;
                    bus.cur_addr <= idx;
                    bus.cur_data <= '0;
                    if (last) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_current_scheduler.sv
// tb_snn_current_scheduler: directed tests with a weight memory and calculator around the scheduler (N=4).
module tb_snn_current_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   e0 = 0;
    int   wre_cnt = 0;
    logic [15:0] mem [16];
    int          wr_addr [$];
    logic [4:0]  wr_data [$];
    int          wr_cyc [$];
    int          done_cyc [$];
    logic [4:0]  exp_basic [4] = '{5'h08, 5'h18, 5'h00, 5'h04};

    snn_current_scheduler_if #(.IDX_W(4)) bus ();

    snn_current_scheduler #(.N_NEURONS(N), .IDX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.w_re) bus.w_data <= mem[bus.w_addr];

    function automatic logic [4:0] calc(input logic [7:0] s, input logic [15:0] w);
        int acc = 0;
        for (int i = 0; i < 8; i++)
            if (s[i]) acc += int'($signed(w[2*i +: 2]));
        return acc[4:0];
    endfunction

    always_comb bus.calc_current = calc(bus.calc_spikes, bus.calc_weights);

    always @(negedge clk) if (rst_n) begin
        if (bus.cur_we) begin
            wr_addr.push_back(int'(bus.cur_addr));
            wr_data.push_back(bus.cur_data);
            wr_cyc.push_back(cyc);
        end
        if (bus.done) done_cyc.push_back(cyc);
        if (bus.w_re) wre_cnt++;
    end

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
        wre_cnt = 0;
    endtask

    task automatic load_basic();
        mem[0] = 16'h5555; mem[1] = 16'hFFFF; mem[2] = 16'h0000; mem[3] = 16'h1111;
    endtask

    task automatic kick(input logic [7:0] s);
        @(negedge clk);
        clear_logs();
        bus.input_spikes = s;
        bus.start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_done(input int n, input int budget);
        int t = 0;
        while (done_cyc.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (done_cyc.size() < n) begin
            errors++;
            $display("FAIL wait_done timeout: done pulses %0d required %0d", done_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.input_spikes = 8'hA5;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", bus.done); end
        checks++; if (bus.cur_we !== 1'b0) begin errors++; $display("FAIL reset cur_we: got %b want 0", bus.cur_we); end
        checks++; if (bus.w_re !== 1'b0) begin errors++; $display("FAIL reset w_re: got %b want 0", bus.w_re); end
        checks++; if (bus.calc_spikes !== 8'h00) begin errors++; $display("FAIL reset calc_spikes: got %h want 00", bus.calc_spikes); end
        checks++; if (bus.calc_weights !== 16'h0000) begin errors++; $display("FAIL reset calc_weights: got %h want 0000", bus.calc_weights); end
        checks++; if (bus.cur_data !== 5'h00 || bus.cur_addr !== 4'h0) begin errors++; $display("FAIL reset cur: got %h/%h want 0/0", bus.cur_addr, bus.cur_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.w_re !== 1'b0) begin errors++; $display("FAIL idle hold: busy %b w_re %b want 0 0", bus.busy, bus.w_re); end
    endtask

    task automatic test_basic();
        load_basic();
        kick(8'hFF);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic busy: got %b want 1", bus.busy); end
        checks++; if (bus.w_re !== 1'b1 || bus.w_addr !== 4'h0) begin errors++; $display("FAIL basic fetch0: w_re %b addr %h want 1 0", bus.w_re, bus.w_addr); end
        @(negedge clk);
        checks++; if (bus.w_re !== 1'b0) begin errors++; $display("FAIL basic w_re pulse: got %b want 0", bus.w_re); end
        wait_done(1, 40);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic busy end: got %b want 0", bus.busy); end
        checks++; if (wr_cyc.size() !== N) begin errors++; $display("FAIL basic writes: got %0d want %0d", wr_cyc.size(), N); end
        for (int k = 0; k < N && k < wr_cyc.size(); k++) begin
            checks++;
            if (wr_addr[k] !== k || wr_data[k] !== exp_basic[k] || wr_cyc[k] !== e0 + 3*k + 3) begin
                errors++;
                $display("FAIL basic write%0d: addr %0d data %h cyc %0d want %0d %h %0d",
                         k, wr_addr[k], wr_data[k], wr_cyc[k] - e0, k, exp_basic[k], 3*k + 3);
            end
        end
        checks++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== e0 + 12) begin
            errors++;
            $display("FAIL basic done: count %0d want 1 at E12", done_cyc.size());
        end
        checks++; if (wre_cnt !== N) begin errors++; $display("FAIL basic w_re count: got %0d want %0d", wre_cnt, N); end
    endtask

    task automatic test_signs();
        logic [4:0] exp_lo [4] = '{5'h1E, 5'h00, 5'h01, 5'h1F};
        logic [4:0] exp_hi [4] = '{5'h00, 5'h01, 5'h01, 5'h1F};
        mem[0] = 16'h0002; mem[1] = 16'h4000; mem[2] = 16'h5555; mem[3] = 16'hFFFF;
        kick(8'h01);
        wait_done(1, 40);
        for (int k = 0; k < N && k < wr_data.size(); k++) begin
            checks++;
            if (wr_data[k] !== exp_lo[k]) begin errors++; $display("FAIL signs spike01 n%0d: got %h want %h", k, wr_data[k], exp_lo[k]); end
        end
        kick(8'h80);
        wait_done(1, 40);
        for (int k = 0; k < N && k < wr_data.size(); k++) begin
            checks++;
            if (wr_data[k] !== exp_hi[k]) begin errors++; $display("FAIL signs spike80 n%0d: got %h want %h", k, wr_data[k], exp_hi[k]); end
        end
    endtask

    task automatic test_ignore();
        load_basic();
        kick(8'hFF);
        wait_until(e0 + 3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.input_spikes = 8'h00;
        wait_done(1, 40);
        wait_until(e0 + 20);
        checks++; if (wr_cyc.size() !== N) begin errors++; $display("FAIL ignore writes: got %0d want %0d", wr_cyc.size(), N); end
        for (int k = 0; k < N && k < wr_data.size(); k++) begin
            checks++;
            if (wr_data[k] !== exp_basic[k]) begin errors++; $display("FAIL ignore n%0d: got %h want %h", k, wr_data[k], exp_basic[k]); end
        end
        checks++; if (bus.calc_spikes !== 8'hFF) begin errors++; $display("FAIL ignore spike_reg: got %h want FF", bus.calc_spikes); end
    endtask

    task automatic test_reset_midrun();
        load_basic();
        kick(8'hFF);
        wait_until(e0 + 4);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.cur_we !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midreset ctl: busy %b we %b done %b want 0 0 0", bus.busy, bus.cur_we, bus.done); end
        checks++; if (bus.calc_weights !== 16'h0 || bus.calc_spikes !== 8'h0) begin errors++; $display("FAIL midreset data: w %h s %h want 0 0", bus.calc_weights, bus.calc_spikes); end
        checks++; if (bus.cur_data !== 5'h0 || bus.cur_addr !== 4'h0 || bus.w_re !== 1'b0) begin errors++; $display("FAIL midreset cur: d %h a %h w_re %b want 0 0 0", bus.cur_data, bus.cur_addr, bus.w_re); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        kick(8'hFF);
        wait_done(1, 40);
        checks++; if (wr_cyc.size() !== N) begin errors++; $display("FAIL midreset rerun writes: got %0d want %0d", wr_cyc.size(), N); end
        for (int k = 0; k < N && k < wr_data.size(); k++) begin
            checks++;
            if (wr_addr[k] !== k || wr_data[k] !== exp_basic[k] || wr_cyc[k] !== e0 + 3*k + 3) begin
                errors++;
                $display("FAIL midreset rerun n%0d: addr %0d data %h cyc %0d want %0d %h %0d",
                         k, wr_addr[k], wr_data[k], wr_cyc[k] - e0, k, exp_basic[k], 3*k + 3);
            end
        end
    endtask

    task automatic test_back_to_back();
        load_basic();
        @(negedge clk);
        clear_logs();
        bus.input_spikes = 8'hFF;
        bus.start = 1'b1;
        e0 = cyc + 1;
        wait_until(e0 + 13);
        bus.start = 1'b0;
        wait_until(e0 + 32);
        checks++; if (wr_cyc.size() !== 2*N) begin errors++; $display("FAIL b2b writes: got %0d want %0d", wr_cyc.size(), 2*N); end
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N && r*N + k < wr_cyc.size(); k++) begin
                checks++;
                if (wr_addr[r*N+k] !== k || wr_data[r*N+k] !== exp_basic[k] || wr_cyc[r*N+k] !== e0 + 13*r + 3*k + 3) begin
                    errors++;
                    $display("FAIL b2b run%0d n%0d: addr %0d data %h cyc %0d want %0d %h %0d", r, k,
                             wr_addr[r*N+k], wr_data[r*N+k], wr_cyc[r*N+k] - e0, k, exp_basic[k], 13*r + 3*k + 3);
                end
            end
        checks++;
        if (done_cyc.size() !== 2 || done_cyc[0] !== e0 + 12 || done_cyc[1] !== e0 + 25) begin
            errors++;
            $display("FAIL b2b done: count %0d want 2 at E12 and E25", done_cyc.size());
        end
    endtask

    task automatic test_zero();
        load_basic();
        kick(8'h00);
        wait_done(1, 40);
        checks++; if (wr_cyc.size() !== N) begin errors++; $display("FAIL zero writes: got %0d want %0d", wr_cyc.size(), N); end
`ifdef SKIP_SILENT_EN
        for (int k = 0; k < N && k < wr_cyc.size(); k++) begin
            checks++;
            if (wr_addr[k] !== k || wr_data[k] !== 5'h00 || wr_cyc[k] !== e0 + k + 1) begin
                errors++;
                $display("FAIL zero n%0d: addr %0d data %h cyc %0d want %0d 00 %0d", k, wr_addr[k], wr_data[k], wr_cyc[k] - e0, k, k + 1);
            end
        end
        checks++; if (wre_cnt !== 0) begin errors++; $display("FAIL zero w_re count: got %0d want 0", wre_cnt); end
        checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== e0 + N) begin errors++; $display("FAIL zero done: count %0d want 1 at E%0d", done_cyc.size(), N); end
`else
        for (int k = 0; k < N && k < wr_cyc.size(); k++) begin
            checks++;
            if (wr_addr[k] !== k || wr_data[k] !== 5'h00 || wr_cyc[k] !== e0 + 3*k + 3) begin
                errors++;
                $display("FAIL zero n%0d: addr %0d data %h cyc %0d want %0d 00 %0d", k, wr_addr[k], wr_data[k], wr_cyc[k] - e0, k, 3*k + 3);
            end
        end
        checks++; if (wre_cnt !== N) begin errors++; $display("FAIL zero w_re count: got %0d want %0d", wre_cnt, N); end
        checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== e0 + 3*N) begin errors++; $display("FAIL zero done: count %0d want 1 at E%0d", done_cyc.size(), 3*N); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        bus.start = 1'b0;
        bus.input_spikes = 8'h00;
        test_reset();
        test_basic();
        test_signs();
        test_ignore();
        test_reset_midrun();
        test_back_to_back();
        test_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
